// File: rtl/c4_pkg.sv
// Shared Connect Four definitions: board size defaults, drop sequencer states and cell colours.
package c4_pkg;

   localparam int unsigned DEFAULT_COLS = 7;
   localparam int unsigned DEFAULT_ROWS = 6;

   typedef enum logic [2:0] {
      StIdle,
      StScan,
      StCommit,
      StSettle,
      StLocked
   } drop_state_t;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P0    = 2'b10;
   localparam logic [1:0] CELL_P1    = 2'b11;

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder; the whole output is forced to zero while en is low.
module onehot_dec #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         onehot[i] = en && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/drop_controller.sv
// Connect Four move sequencer: scans a column bottom-up and strobes the first empty cell.
// Define DROP_CTRL_EDGE_EN to treat drop as a level and act only on its rising edge.
module drop_controller
   import c4_pkg::*;
#(
   parameter int unsigned COLS = DEFAULT_COLS,
   parameter int unsigned ROWS = DEFAULT_ROWS,
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned OW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1,
   localparam int unsigned MW = $clog2(COLS * ROWS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 drop,
   input  logic [CW-1:0]        col_sel,
   input  logic [COLS*ROWS-1:0] occupied,
   input  logic [1:0]           win,
   output logic [COLS-1:0]      column,
   output logic [ROWS-1:0]      cell_,
   output logic                 change,
   output logic                 player_colour,
   output logic                 busy,
   output logic                 reject,
   output logic [MW-1:0]        move_count,
   output logic                 draw
);

   drop_state_t   state;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [OW-1:0] occ_idx;
   logic          req;
   logic          unused_win;

   // The winner colour belongs to the display logic, not to move sequencing.
   assign unused_win = win[0];

`ifdef DROP_CTRL_EDGE_EN
   logic drop_prev;

   // Tracks drop even through reset so a level held across reset release is not an edge.
   always_ff @(posedge clk) begin
      drop_prev <= drop;
   end

   assign req = drop & ~drop_prev;
`else
   assign req = drop;
`endif

   assign occ_idx = OW'(col_q * ROWS + row_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         col_q         <= '0;
         row_q         <= '0;
         player_colour <= 1'b0;
         reject        <= 1'b0;
         move_count    <= '0;
         draw          <= 1'b0;
      end else begin
         reject <= 1'b0;
         case (state)
            StIdle: begin
               if (win[1]) begin
                  state <= StLocked;
               end else if (req) begin
                  if (32'(col_sel) >= COLS) begin
                     reject <= 1'b1;
                  end else begin
                     col_q <= col_sel;
                     row_q <= '0;
                     state <= StScan;
                  end
               end
            end
            StScan: begin
               if (win[1]) begin
                  state <= StLocked;
               end else if (!occupied[occ_idx]) begin
                  state <= StCommit;
               end else if (row_q == RW'(ROWS - 1)) begin
                  reject <= 1'b1;
                  state  <= StIdle;
               end else begin
                  row_q <= row_q + 1'b1;
               end
            end
            StCommit: begin
               player_colour <= ~player_colour;
               if (move_count != MW'(COLS * ROWS)) begin
                  move_count <= move_count + 1'b1;
               end
               state <= StSettle;
            end
            StSettle: begin
               if (win[1]) begin
                  state <= StLocked;
               end else if (move_count == MW'(COLS * ROWS)) begin
                  draw  <= 1'b1;
                  state <= StLocked;
               end else begin
                  state <= StIdle;
               end
            end
            StLocked: state <= StLocked;
            default:  state <= StIdle;
         endcase
      end
   end

   assign change = (state == StCommit);
   assign busy   = (state == StScan) || (state == StCommit) || (state == StSettle);

   onehot_dec #(
      .WIDTH (COLS),
      .IDX_W (CW)
   ) u_col_dec (
      .en     (change),
      .idx    (col_q),
      .onehot (column)
   );

   onehot_dec #(
      .WIDTH (ROWS),
      .IDX_W (RW)
   ) u_row_dec (
      .en     (change),
      .idx    (row_q),
      .onehot (cell_)
   );

endmodule
